// File: rtl/cr_kme_pkg.sv
// Shared KME package.
// Holds the default payload width and skid depth used by the stall-flow TX
// adapter, plus a small helper for the skid occupancy update.
package cr_kme_pkg;

  localparam int unsigned CR_KME_DATA_W        = 256;
  localparam int unsigned CR_KME_TX_SKID_DEPTH = 2;

  // Skid buffer occupancy values (count is 0..2).
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_cnt_e;

  // Occupancy after one cycle. Push and pop together leave it unchanged.
  function automatic logic [1:0] skid_count_next(input logic [1:0] cnt,
                                                 input logic       push,
                                                 input logic       pop);
    logic [1:0] nxt;
    nxt = cnt;
    if (push && !pop) nxt = cnt + 2'd1;
    if (pop && !push) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/cr_kme_stall_tx_skid.sv
// 2-entry skid buffer for the KME stall-flow TX adapter.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push         - write push_data into the tail entry
//   push_data    - payload to store
//   pop          - retire the head entry
//   head_data    - payload at the head (valid while count != 0)
//   count        - occupancy, 0..2
// The caller guarantees no push when full and no pop when empty.
module cr_kme_stall_tx_skid
  import cr_kme_pkg::*;
#(
  parameter int unsigned DATA_W     = CR_KME_DATA_W,
  parameter int unsigned SKID_DEPTH = CR_KME_TX_SKID_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;

  // Storage is not reset: a word is only ever read after it was written,
  // and reset clears count, so stale contents can never reach the output.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= SKID_EMPTY;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= skid_count_next(count, push, pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/cr_kme_stall_tx.sv
// Transmit-side adapter feeding a stall-flow-controlled KME FIFO input from
// a valid/ready source. The downstream stall is registered (stall_q) to cut
// the combinational stall path, a 2-entry skid buffer absorbs the resulting
// stall latency, and the FIFO-side outputs are fully registered.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_data/in_valid  - upstream payload and word-present
//   in_ready          - accepts in_data this cycle (decoded from state only)
//   fifo_in           - payload to downstream FIFO
//   fifo_in_valid     - write strobe to downstream FIFO
//   fifo_in_stall     - downstream requests no further writes
//   idle              - buffer empty and no output word pending
// Optional macro CR_KME_STALL_TX_STATS_EN adds:
//   stat_words_sent   - cycles with fifo_in_valid=1 (wraps)
//   stat_stall_cycles - cycles with stall_q=1 and buffer non-empty (wraps)
module cr_kme_stall_tx
  import cr_kme_pkg::*;
#(
  parameter int unsigned DATA_W     = CR_KME_DATA_W,
  parameter int unsigned SKID_DEPTH = CR_KME_TX_SKID_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] fifo_in,
  output logic              fifo_in_valid,
  input  logic              fifo_in_stall,
  output logic              idle
`ifdef CR_KME_STALL_TX_STATS_EN
  ,
  output logic [31:0]       stat_words_sent,
  output logic [31:0]       stat_stall_cycles
`endif
);

  logic              stall_q;
  logic              push;
  logic              pop;
  logic [1:0]        count;
  logic [DATA_W-1:0] head_data;

  cr_kme_stall_tx_skid #(
    .DATA_W     (DATA_W),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  assign in_ready = (count != SKID_FULL);
  assign push     = in_valid & in_ready;
  // Pop uses the registered stall, so up to two writes land after the
  // downstream raises stall; the downstream reserves that headroom.
  assign pop      = (count != SKID_EMPTY) & ~stall_q;
  assign idle     = (count == SKID_EMPTY) & ~fifo_in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q       <= 1'b0;
      fifo_in_valid <= 1'b0;
      fifo_in       <= '0;
    end else begin
      stall_q       <= fifo_in_stall;
      fifo_in_valid <= pop;
      if (pop) fifo_in <= head_data;
    end
  end

`ifdef CR_KME_STALL_TX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_sent   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (fifo_in_valid)                      stat_words_sent   <= stat_words_sent + 32'd1;
      if (stall_q && (count != SKID_EMPTY))   stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cr_kme_stall_tx.sv
module tb_cr_kme_stall_tx;

  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] fifo_in;
  logic          fifo_in_valid;
  logic          fifo_in_stall;
  logic          idle;
`ifdef CR_KME_STALL_TX_STATS_EN
  logic [31:0]   stat_words_sent;
  logic [31:0]   stat_stall_cycles;
`endif

  cr_kme_stall_tx #(
    .DATA_W     (DW),
    .SKID_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fifo_in       (fifo_in),
    .fifo_in_valid (fifo_in_valid),
    .fifo_in_stall (fifo_in_stall),
    .idle          (idle)
`ifdef CR_KME_STALL_TX_STATS_EN
    ,
    .stat_words_sent   (stat_words_sent),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: a queue holding buffered words, the registered
  // stall, and the registered output word.
  logic [DW-1:0] mq[$];
  logic          m_stall_q;
  logic          m_valid;
  logic [DW-1:0] m_data;
  int unsigned   m_words;
  int unsigned   m_stalls;
  logic [DW-1:0] sent[$];
  logic [DW-1:0] rcvd[$];

  task automatic model_clear();
    mq.delete();
    sent.delete();
    rcvd.delete();
    m_stall_q = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_words   = 0;
    m_stalls  = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and wait past the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic st);
    bit acc;
    bit rel;
    in_valid      = v;
    in_data       = d;
    fifo_in_stall = st;
    acc = v && (mq.size() < 2);
    rel = (mq.size() > 0) && !m_stall_q;
    if (m_valid) m_words++;
    if (m_stall_q && mq.size() != 0) m_stalls++;
    if (acc) sent.push_back(d);
    if (rel) begin
      m_data  = mq.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (acc) mq.push_back(d);
    m_stall_q = st;
    @(posedge clk);
    #1;
    if (fifo_in_valid) rcvd.push_back(fifo_in);
  endtask

  task automatic apply_reset();
    in_valid      = 1'b0;
    in_data       = '0;
    fifo_in_stall = 1'b0;
    rst_n         = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid      = 1'b0;
    in_data       = '0;
    fifo_in_stall = 1'b0;
    rst_n         = 1'b0;
    #3;
    n_checks++; if (fifo_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", fifo_in_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", idle); end
    n_checks++; if (fifo_in !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", fifo_in); end
`ifdef CR_KME_STALL_TX_STATS_EN
    n_checks++; if (stat_words_sent !== 32'd0 || stat_stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_words_sent, stat_stall_cycles); end
`endif
    apply_reset();
  endtask

  task automatic test_latency();
    logic [DW-1:0] one;
    one = DW'(1);
    apply_reset();
    step(1'b1, one, 1'b0);
    n_checks++; if (fifo_in_valid !== 1'b0 || idle !== 1'b0) begin
      n_fail++; $display("FAIL lat_edge0 got valid=%b idle=%b exp valid=0 idle=0", fifo_in_valid, idle); end
    step(1'b0, '0, 1'b0);
    n_checks++; if (fifo_in_valid !== 1'b1 || fifo_in !== one) begin
      n_fail++; $display("FAIL lat_write got valid=%b data=%h exp valid=1 data=1", fifo_in_valid, fifo_in); end
    step(1'b0, '0, 1'b0);
    n_checks++; if (fifo_in_valid !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL lat_idle got valid=%b idle=%b exp valid=0 idle=1", fifo_in_valid, idle); end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      if (k < 8) step(1'b1, DW'(16 + k), 1'b0);
      else       step(1'b0, '0, 1'b0);
      n_checks++; if (fifo_in_valid !== ((k >= 1) && (k <= 8))) begin
        n_fail++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, fifo_in_valid, (k >= 1) && (k <= 8)); end
      n_checks++; if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready); end
    end
    n_checks++; if (rcvd.size() != 8) begin
      n_fail++; $display("FAIL stream_count got=%0d exp=8", rcvd.size()); end
    for (int k = 0; k < 8 && k < rcvd.size(); k++) begin
      n_checks++; if (rcvd[k] !== DW'(16 + k)) begin
        n_fail++; $display("FAIL stream_order k=%0d got=%h exp=%h", k, rcvd[k], DW'(16 + k)); end
    end
  endtask

  task automatic test_stall();
    int writes_after;
    int seq;
    apply_reset();
    writes_after = 0;
    seq = 0;
    for (int k = 0; k < 20; k++) begin
      logic v;
      v = (k < 14);
      step(v, DW'(32'h100 + seq), (k >= 4) && (k <= 8));
      if (v && sent.size() > seq) seq++;
      n_checks++; if (fifo_in_valid !== m_valid || (m_valid && fifo_in !== m_data)) begin
        n_fail++; $display("FAIL stall_out k=%0d got=%b/%h exp=%b/%h", k, fifo_in_valid, fifo_in, m_valid, m_data); end
      n_checks++; if (in_ready !== (mq.size() != 2)) begin
        n_fail++; $display("FAIL stall_ready k=%0d got=%b exp=%b", k, in_ready, mq.size() != 2); end
      if (k >= 3 && k <= 9 && fifo_in_valid) writes_after++;
      if (k >= 5 && k <= 9) begin
        n_checks++; if (fifo_in_valid !== 1'b0) begin
          n_fail++; $display("FAIL stall_hold k=%0d got=%b exp=0", k, fifo_in_valid); end
      end
      if (k == 10) begin
        n_checks++; if (fifo_in_valid !== 1'b1) begin
          n_fail++; $display("FAIL stall_resume got=%b exp=1", fifo_in_valid); end
      end
    end
    n_checks++; if (writes_after > 2) begin
      n_fail++; $display("FAIL stall_headroom got=%0d exp<=2", writes_after); end
    n_checks++; if (rcvd.size() != sent.size() || rcvd != sent) begin
      n_fail++; $display("FAIL stall_seq got=%0d words exp=%0d words in order", rcvd.size(), sent.size()); end
  endtask

  task automatic test_push_pop();
    apply_reset();
    step(1'b1, DW'(32'hA0), 1'b0);
    for (int k = 1; k < 4; k++) begin
      step(1'b1, DW'(32'hA0 + k), 1'b0);
      n_checks++; if (dut.u_skid.count !== 2'd1) begin
        n_fail++; $display("FAIL pushpop_count k=%0d got=%0d exp=1", k, dut.u_skid.count); end
    end
    repeat (3) step(1'b0, '0, 1'b0);
    n_checks++; if (rcvd.size() != 4) begin
      n_fail++; $display("FAIL pushpop_words got=%0d exp=4", rcvd.size()); end
    for (int k = 0; k < 4 && k < rcvd.size(); k++) begin
      n_checks++; if (rcvd[k] !== DW'(32'hA0 + k)) begin
        n_fail++; $display("FAIL pushpop_order k=%0d got=%h exp=%h", k, rcvd[k], DW'(32'hA0 + k)); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step(1'b1, DW'(32'hC0), 1'b1);
    step(1'b1, DW'(32'hC1), 1'b1);
    n_checks++; if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_full got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    fifo_in_stall = 1'b0;
    rst_n = 1'b0;
    model_clear();
    #2;
    n_checks++; if (fifo_in_valid !== 1'b0 || in_ready !== 1'b1 || idle !== 1'b1) begin
      n_fail++; $display("FAIL rmid_state got valid=%b ready=%b idle=%b exp 0/1/1", fifo_in_valid, in_ready, idle); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b0);
      n_checks++; if (fifo_in_valid !== 1'b0 || idle !== 1'b1) begin
        n_fail++; $display("FAIL rmid_stale k=%0d got valid=%b idle=%b exp 0/1", k, fifo_in_valid, idle); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      logic [DW-1:0] d;
      for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom();
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 4) == 0);
      n_checks++; if (fifo_in_valid !== m_valid || (m_valid && fifo_in !== m_data)) begin
        n_fail++; $display("FAIL rand_out k=%0d got=%b/%h exp=%b/%h", k, fifo_in_valid, fifo_in, m_valid, m_data); end
      n_checks++; if (in_ready !== (mq.size() != 2) || idle !== (mq.size() == 0 && !m_valid)) begin
        n_fail++; $display("FAIL rand_ctl k=%0d got ready=%b idle=%b exp ready=%b idle=%b",
                           k, in_ready, idle, mq.size() != 2, mq.size() == 0 && !m_valid); end
    end
    repeat (4) step(1'b0, '0, 1'b0);
    n_checks++; if (rcvd.size() != sent.size() || rcvd != sent) begin
      n_fail++; $display("FAIL rand_seq got=%0d words exp=%0d words in order", rcvd.size(), sent.size()); end
  endtask

`ifdef CR_KME_STALL_TX_STATS_EN
  task automatic test_stats();
    int w;
    apply_reset();
    w = 0;
    for (int k = 0; k < 16; k++) begin
      logic v;
      v = (w < 6);
      if (v && mq.size() < 2) w++;
      step(v, DW'(32'hE0 + k), (k >= 1) && (k <= 3));
    end
    n_checks++; if (stat_words_sent !== 32'd6 || stat_words_sent !== m_words) begin
      n_fail++; $display("FAIL stats_words got=%0d exp=6", stat_words_sent); end
    n_checks++; if (stat_stall_cycles !== 32'd3 || stat_stall_cycles !== m_stalls) begin
      n_fail++; $display("FAIL stats_stalls got=%0d exp=3", stat_stall_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_stall();
    test_push_pop();
    test_reset_mid();
    test_random();
`ifdef CR_KME_STALL_TX_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached got=running exp=finished");
    $fatal(1);
  end

endmodule
